// File: rtl/matrix_alu_pkg.sv
// Shared definitions for the matrix ALU and the blocks that drive its
// register bus: register offsets, opcodes, the packed 4x4 matrix type and
// the command sequencer state encoding.
package matrix_alu_pkg;

  // ALU register offsets, carried in address[7:0]
  localparam logic [7:0] AluStatusIn  = 8'h00;
  localparam logic [7:0] AluStatusOut = 8'h01;
  localparam logic [7:0] ALU_Source1  = 8'h02;
  localparam logic [7:0] ALU_Source2  = 8'h03;
  localparam logic [7:0] ALU_Result   = 8'h04;
  localparam logic [7:0] Overflow_err = 8'h05;

  // ALU operation codes
  localparam logic [7:0] MMult1     = 8'h00;
  localparam logic [7:0] MMult2     = 8'h01;
  localparam logic [7:0] MMult3     = 8'h02;
  localparam logic [7:0] Madd       = 8'h03;
  localparam logic [7:0] Msub       = 8'h04;
  localparam logic [7:0] Mtranspose = 8'h05;
  localparam logic [7:0] MScale     = 8'h06;
  localparam logic [7:0] MScaleImm  = 8'h07;

  // 4x4 matrix of 16-bit elements, row-major: element [r][c]
  typedef logic [3:0][3:0][15:0] mat4x4_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_SRC1,
    S_WR_SRC2,
    S_GO,
    S_POLL,
    S_RD_RES,
    S_RESP
  } seq_state_e;

endpackage

// File: rtl/matrix_alu_sequencer.sv
// Command sequencer for the matrix ALU. Accepts one operation on the cmd
// valid/ready interface, runs the fixed bus sequence Source1 write,
// Source2 write, StatusIn go, StatusOut poll, Result read, and returns the
// result on the rsp valid/ready interface. One operation in flight.
//
// Ports:
//   Clk, nReset          clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready  command handshake; cmd_opcode, cmd_src1, cmd_src2
//   rsp_valid/rsp_ready  response handshake; rsp_data, rsp_timeout, rsp_bad_op
//   busy                 high whenever not idle
//   address, nRead, nWrite, ExeDataOut   registered ALU bus outputs
//   MatrixDataOut        ALU read data, sampled at the end of the read cycle
module matrix_alu_sequencer
  import matrix_alu_pkg::*;
#(
  parameter logic [3:0]  ALU_EN         = 4'h3,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned NUM_OPS        = 8
) (
  input  logic         Clk,
  input  logic         nReset,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [7:0]   cmd_opcode,
  input  logic [255:0] cmd_src1,
  input  logic [255:0] cmd_src2,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [255:0] rsp_data,
  output logic         rsp_timeout,
  output logic         rsp_bad_op,
  output logic         busy,
  output logic [15:0]  address,
  output logic         nRead,
  output logic         nWrite,
  output logic [255:0] ExeDataOut,
  input  logic [255:0] MatrixDataOut
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [8:0]       OP_LIMIT = 9'(NUM_OPS);

  seq_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         op_q, op_d;
  logic [255:0]       src1_q, src1_d;
  logic [255:0]       src2_q, src2_d;
  logic [255:0]       rsp_data_q, rsp_data_d;
  logic               rsp_timeout_q, rsp_timeout_d;
  logic               rsp_bad_op_q, rsp_bad_op_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               busy_q, busy_d;
  logic [15:0]        addr_q, addr_d;
  logic               nread_q, nread_d;
  logic               nwrite_q, nwrite_d;
  logic [255:0]       exe_q, exe_d;

  // Sequencing and response capture
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    op_d          = op_q;
    src1_d        = src1_q;
    src2_d        = src2_q;
    rsp_data_d    = rsp_data_q;
    rsp_timeout_d = rsp_timeout_q;
    rsp_bad_op_d  = rsp_bad_op_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d          = cmd_opcode;
          src1_d        = cmd_src1;
          src2_d        = cmd_src2;
          // Cleared here so timeout and bad-op responses report zero data
          rsp_data_d    = '0;
          rsp_timeout_d = 1'b0;
          if ({1'b0, cmd_opcode} >= OP_LIMIT) begin
            rsp_bad_op_d = 1'b1;
            state_d      = S_RESP;
          end else begin
            rsp_bad_op_d = 1'b0;
            state_d      = S_WR_SRC1;
          end
        end
      end
      S_WR_SRC1: state_d = S_WR_SRC2;
      S_WR_SRC2: state_d = S_GO;
      S_GO: begin
        cnt_d   = '0;
        state_d = S_POLL;
      end
      S_POLL: begin
        // Done has priority, so a ready flag on the last poll still succeeds
        if (MatrixDataOut[0]) begin
          state_d = S_RD_RES;
        end else if (cnt_q == CNT_LAST) begin
          rsp_timeout_d = 1'b1;
          state_d       = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RD_RES: begin
        rsp_data_d = MatrixDataOut;
        state_d    = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_timeout_d = 1'b0;
          rsp_bad_op_d  = 1'b0;
          state_d       = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus-cycle encoder: decoded from the next state so the registered bus
  // outputs line up with the state they belong to.
  always_comb begin
    addr_d      = '0;
    nread_d     = 1'b1;
    nwrite_d    = 1'b1;
    exe_d       = '0;
    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    rsp_valid_d = (state_d == S_RESP);
    unique case (state_d)
      S_WR_SRC1: begin
        addr_d   = {ALU_EN, 4'h0, ALU_Source1};
        nwrite_d = 1'b0;
        exe_d    = src1_d;
      end
      S_WR_SRC2: begin
        addr_d   = {ALU_EN, 4'h0, ALU_Source2};
        nwrite_d = 1'b0;
        exe_d    = src2_d;
      end
      S_GO: begin
        addr_d = {ALU_EN, 4'h0, AluStatusIn};
        exe_d  = {248'h0, op_d};
      end
      S_POLL: begin
        addr_d  = {ALU_EN, 4'h0, AluStatusOut};
        nread_d = 1'b0;
      end
      S_RD_RES: begin
        addr_d  = {ALU_EN, 4'h0, ALU_Result};
        nread_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      op_q          <= '0;
      src1_q        <= '0;
      src2_q        <= '0;
      rsp_data_q    <= '0;
      rsp_timeout_q <= 1'b0;
      rsp_bad_op_q  <= 1'b0;
      cmd_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      addr_q        <= '0;
      nread_q       <= 1'b1;
      nwrite_q      <= 1'b1;
      exe_q         <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      op_q          <= op_d;
      src1_q        <= src1_d;
      src2_q        <= src2_d;
      rsp_data_q    <= rsp_data_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_bad_op_q  <= rsp_bad_op_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      busy_q        <= busy_d;
      addr_q        <= addr_d;
      nread_q       <= nread_d;
      nwrite_q      <= nwrite_d;
      exe_q         <= exe_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_timeout = rsp_timeout_q;
  assign rsp_bad_op  = rsp_bad_op_q;
  assign busy        = busy_q;
  assign address     = addr_q;
  assign nRead       = nread_q;
  assign nWrite      = nwrite_q;
  assign ExeDataOut  = exe_q;

endmodule

// File: tb/tb_matrix_alu_sequencer.sv
// Bench for matrix_alu_sequencer. A simple ALU model answers the bus; a
// per-cycle script holds both the stimulus and the expected outputs, built
// from the operation-level latency rules of the sequencer.
module tb_matrix_alu_sequencer;
  import matrix_alu_pkg::*;

  localparam int unsigned TMO  = 16;
  localparam int unsigned NOPS = 8;

  logic         Clk = 1'b0;
  logic         nReset;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [7:0]   cmd_opcode;
  logic [255:0] cmd_src1, cmd_src2;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [255:0] rsp_data;
  logic         rsp_timeout, rsp_bad_op, busy;
  logic [15:0]  address;
  logic         nRead, nWrite;
  logic [255:0] ExeDataOut;
  logic [255:0] MatrixDataOut;

  always #5 Clk = ~Clk;

  matrix_alu_sequencer #(
    .ALU_EN(4'h3),
    .TIMEOUT_CYCLES(16),
    .NUM_OPS(8)
  ) dut (
    .Clk(Clk), .nReset(nReset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_src1(cmd_src1), .cmd_src2(cmd_src2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_timeout(rsp_timeout), .rsp_bad_op(rsp_bad_op), .busy(busy),
    .address(address), .nRead(nRead), .nWrite(nWrite),
    .ExeDataOut(ExeDataOut), .MatrixDataOut(MatrixDataOut)
  );

  // ALU behaviour: element-wise / matrix maths on 16-bit elements
  function automatic logic [255:0] alu_calc(input logic [7:0] op,
                                            input logic [255:0] a,
                                            input logic [255:0] b);
    mat4x4_t ma, mb, mr;
    ma = a; mb = b; mr = '0;
    for (int unsigned r = 0; r < 4; r++)
      for (int unsigned c = 0; c < 4; c++)
        case (op)
          8'd0, 8'd1, 8'd2:
            for (int unsigned k = 0; k < 4; k++)
              mr[r][c] = mr[r][c] + 16'(ma[r][k] * mb[k][c]);
          8'd3: mr[r][c] = ma[r][c] + mb[r][c];
          8'd4: mr[r][c] = ma[r][c] - mb[r][c];
          8'd5: mr[r][c] = ma[c][r];
          default: mr[r][c] = 16'(ma[r][c] * mb[0][0]);
        endcase
    return mr;
  endfunction

  // Bench-side ALU: stores sources, computes on go, reports done after
  // alu_dly zero-valued status polls.
  int unsigned  alu_delay;
  int unsigned  alu_dly;
  int unsigned  alu_polls;
  logic [255:0] alu_s1, alu_s2, alu_res;

  initial begin
    alu_dly = 0; alu_polls = 0; alu_s1 = '0; alu_s2 = '0; alu_res = '0;
  end

  always @(posedge Clk) begin
    if (address[15:12] == 4'h3) begin
      if (!nWrite && address[7:0] == 8'd2) alu_s1 <= ExeDataOut;
      if (!nWrite && address[7:0] == 8'd3) alu_s2 <= ExeDataOut;
      if (nWrite && nRead && address[7:0] == 8'd0) begin
        alu_res   <= alu_calc(ExeDataOut[7:0], alu_s1, alu_s2);
        alu_polls <= 0;
        alu_dly   <= alu_delay;
      end
      if (!nRead && address[7:0] == 8'd1) alu_polls <= alu_polls + 1;
    end
  end

  always_comb begin
    MatrixDataOut = '0;
    if (!nRead && address[15:12] == 4'h3) begin
      if (address[7:0] == 8'd1) MatrixDataOut[0] = (alu_polls >= alu_dly);
      if (address[7:0] == 8'd4) MatrixDataOut = alu_res;
    end
  end

  // One script entry per clock cycle: inputs for the cycle and expectations
  typedef struct {
    logic         cv;
    logic [7:0]   op;
    logic [255:0] s1, s2;
    logic         rr;
    int unsigned  dly;
    logic         mark;
    logic         x_ready, x_busy, x_valid, x_to, x_bad, x_chkd;
    logic [255:0] x_data;
    logic [15:0]  x_addr;
    logic         x_nr, x_nw;
    logic [255:0] x_exe;
  } cyc_t;

  cyc_t scr[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   last_lat = -1;
  logic [255:0] last_data = '0;
  logic rv_prev = 1'b0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
  endtask

  function automatic logic [15:0] ba(input logic [7:0] r);
    return {4'h3, 4'h0, r};
  endfunction

  function automatic cyc_t idle_e();
    cyc_t e;
    e.cv = 0; e.op = '0; e.s1 = '0; e.s2 = '0; e.rr = 1; e.dly = 0; e.mark = 0;
    e.x_ready = 1; e.x_busy = 0; e.x_valid = 0; e.x_to = 0; e.x_bad = 0;
    e.x_chkd = 0; e.x_data = '0; e.x_addr = '0; e.x_nr = 1; e.x_nw = 1; e.x_exe = '0;
    return e;
  endfunction

  function automatic cyc_t busy_e(input logic [15:0] a, input logic nr,
                                  input logic nw, input logic [255:0] x);
    cyc_t e;
    e = idle_e();
    e.x_ready = 0; e.x_busy = 1; e.x_addr = a; e.x_nr = nr; e.x_nw = nw; e.x_exe = x;
    return e;
  endfunction

  task automatic add_idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) scr.push_back(idle_e());
  endtask

  // Expected cycle-by-cycle behaviour of one operation: accept in IDLE,
  // three setup cycles, polls until done or limit, result read, response.
  task automatic add_op(input logic [7:0] op, input logic [255:0] a,
                        input logic [255:0] b, input int unsigned d,
                        input int unsigned h);
    cyc_t e;
    logic [255:0] res;
    logic to, bad;
    int unsigned polls;
    e = idle_e();
    e.cv = 1; e.op = op; e.s1 = a; e.s2 = b; e.dly = d; e.mark = 1;
    scr.push_back(e);
    res = '0; to = 0; bad = 0;
    if (op >= NOPS) begin
      bad = 1;
    end else begin
      scr.push_back(busy_e(ba(8'd2), 1, 0, a));
      scr.push_back(busy_e(ba(8'd3), 1, 0, b));
      scr.push_back(busy_e(ba(8'd0), 1, 1, {248'h0, op}));
      polls = (d < TMO) ? d + 1 : TMO;
      for (int unsigned i = 0; i < polls; i++) scr.push_back(busy_e(ba(8'd1), 0, 1, '0));
      if (d < TMO) begin
        scr.push_back(busy_e(ba(8'd4), 0, 1, '0));
        res = alu_calc(op, a, b);
      end else begin
        to = 1;
      end
    end
    for (int unsigned i = 0; i <= h; i++) begin
      e = busy_e(16'h0000, 1, 1, '0);
      e.x_valid = 1; e.x_to = to; e.x_bad = bad; e.x_data = res; e.x_chkd = 1;
      e.rr = (i == h);
      scr.push_back(e);
    end
  endtask

  // Present the next command on the last n scripted cycles (held cmd_valid)
  task automatic patch_tail(input int unsigned n, input logic [7:0] op,
                            input logic [255:0] a, input logic [255:0] b);
    cyc_t e;
    for (int unsigned i = scr.size() - n; i < scr.size(); i++) begin
      e = scr[i];
      e.cv = 1; e.op = op; e.s1 = a; e.s2 = b; e.dly = 0;
      scr[i] = e;
    end
  endtask

  task automatic cmp_cycle(input cyc_t e);
    chk("cmd_ready", 256'(cmd_ready), 256'(e.x_ready));
    chk("busy", 256'(busy), 256'(e.x_busy));
    chk("rsp_valid", 256'(rsp_valid), 256'(e.x_valid));
    chk("rsp_timeout", 256'(rsp_timeout), 256'(e.x_to));
    chk("rsp_bad_op", 256'(rsp_bad_op), 256'(e.x_bad));
    chk("address", 256'(address), 256'(e.x_addr));
    chk("nRead", 256'(nRead), 256'(e.x_nr));
    chk("nWrite", 256'(nWrite), 256'(e.x_nw));
    chk("ExeDataOut", ExeDataOut, e.x_exe);
    if (e.x_chkd) chk("rsp_data", rsp_data, e.x_data);
  endtask

  task automatic run(input int unsigned n);
    cyc_t e;
    for (int unsigned k = 0; k < n && scr.size() > 0; k++) begin
      e = scr.pop_front();
      @(posedge Clk); #1;
      cmd_valid = e.cv; cmd_opcode = e.op; cmd_src1 = e.s1; cmd_src2 = e.s2;
      rsp_ready = e.rr;
      if (e.cv) alu_delay = e.dly;
      if (e.mark) acc_cyc = cyc;
      @(negedge Clk);
      cmp_cycle(e);
      if (rsp_valid && !rv_prev) begin
        last_lat  = cyc - acc_cyc;
        last_data = rsp_data;
      end
      rv_prev = rsp_valid;
      cyc++;
    end
  endtask

  task automatic run_all();
    run(100000);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, 256'(busy), 256'(0));
    chk({tag, "_cmd_ready"}, 256'(cmd_ready), 256'(1));
    chk({tag, "_address"}, 256'(address), 256'(0));
    chk({tag, "_nRead"}, 256'(nRead), 256'(1));
    chk({tag, "_nWrite"}, 256'(nWrite), 256'(1));
    chk({tag, "_exe"}, ExeDataOut, '0);
    chk({tag, "_rsp_valid"}, 256'(rsp_valid), 256'(0));
    chk({tag, "_rsp_data"}, rsp_data, '0);
    chk({tag, "_flags"}, 256'({rsp_timeout, rsp_bad_op}), 256'(0));
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int unsigned i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  initial begin
    logic [255:0] ones, twos, threes, ramp, tr;
    int unsigned dtab[8];
    int unsigned r, d, h;
    logic [7:0] op;

    dtab = '{0, 1, 2, 3, 5, 15, 16, 40};
    ones = {16{16'h0001}}; twos = {16{16'h0002}}; threes = {16{16'h0003}};
    for (int unsigned i = 0; i < 16; i++) ramp[i*16 +: 16] = 16'(i);

    nReset = 0; cmd_valid = 0; cmd_opcode = '0; cmd_src1 = '0; cmd_src2 = '0;
    rsp_ready = 1; alu_delay = 0;

    // Hand-computed pins for the ALU model
    chk("pin_madd", alu_calc(Madd, ones, twos), threes);
    tr = alu_calc(Mtranspose, ramp, '0);
    chk("pin_transpose01", 256'(tr[31:16]), 256'(16'd4));
    chk("pin_scaleimm", alu_calc(MScaleImm, twos, 256'(16'd3)), {16{16'h0006}});

    // Reset state
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk_reset_outputs("reset");
    nReset = 1;
    add_idle(2); run_all();

    // Madd, done on first poll
    add_op(Madd, ones, twos, 0, 0); add_idle(1); run_all();
    chk("madd_latency", 256'(last_lat), 256'(6));
    chk("madd_data", last_data, threes);

    // Slow status: three not-done polls
    add_op(Madd, ones, twos, 3, 0); add_idle(1); run_all();
    chk("slow_latency", 256'(last_lat), 256'(9));
    chk("slow_data", last_data, threes);

    // Status never done: 16 polls then timeout response
    add_op(Madd, ones, twos, 1000, 0); add_idle(1); run_all();
    chk("timeout_latency", 256'(last_lat), 256'(20));
    chk("timeout_data", last_data, '0);

    // Illegal opcode goes straight to the response
    add_op(8'h09, ones, twos, 0, 1); add_idle(1); run_all();
    chk("badop_latency", 256'(last_lat), 256'(1));

    // Backpressure with a second command held during the response
    add_op(Madd, ramp, twos, 0, 5);
    patch_tail(6, Mtranspose, ramp, ones);
    add_op(Mtranspose, ramp, ones, 0, 0);
    add_idle(2); run_all();
    chk("b2b_data", last_data, tr);

    // Asynchronous reset in the middle of polling
    add_op(Madd, ones, twos, 1000, 0);
    run(7);
    scr.delete();
    @(posedge Clk); #3;
    nReset = 0;
    #1;
    chk_reset_outputs("async_reset");
    @(negedge Clk);
    cmd_valid = 0;
    nReset = 1;
    rv_prev = 1'b0;
    add_idle(2); run_all();

    // Randomized operations
    for (int unsigned i = 0; i < 40; i++) begin
      r  = $urandom_range(0, 11);
      op = (r < 8) ? 8'(r) : 8'($urandom_range(8, 255));
      d  = dtab[$urandom_range(0, 7)];
      h  = $urandom_range(0, 3);
      add_op(op, rnd256(), rnd256(), d, h);
      if ($urandom_range(0, 1) == 1) add_idle($urandom_range(1, 2));
      run_all();
    end
    add_idle(2); run_all();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
